// File: rtl/memreg_fifo.sv
// Synchronous FIFO over a flip-flop register array with valid/ready ports,
// a head-relative peek port and a sticky overflow flag.
module memreg_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [AW-1:0]    peek_addr,
  output logic [WIDTH-1:0] peek_data,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  (* mem2reg *) logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;
  logic [AW-1:0] peek_idx;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (in_valid && !in_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      // NOTE: the array lives in flops, so it is cleared like any other state;
      // this keeps peek/out data deterministic after a mid-stream reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Peek index wraps naturally in AW bits; offsets beyond the fill level read 0.
  assign peek_idx  = rd_ptr_q + peek_addr;
  assign peek_data = ({1'b0, peek_addr} < count_q) ? mem_q[peek_idx] : '0;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_memreg_fifo.sv
// Scoreboarded bench for memreg_fifo: directed pushes queue expected words,
// a negedge monitor compares every accepted pop against the queue.
module tb_memreg_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] peek_addr;
  logic [3:0] peek_data;
  logic [3:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_fails  = 0;
  logic [3:0] exp_q[$];

  memreg_fifo #(.WIDTH(4), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .peek_addr(peek_addr), .peek_data(peek_data),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a push that the bench knows will be accepted, recording the word.
  task automatic push_word(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    step();
  endtask

  // Monitor: inputs are stable mid-cycle, so a handshake seen at negedge is
  // the one taken on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_pop: got %0d expected none", out_data);
      end else begin
        check("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; peek_addr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_peek", peek_data, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);

    // Push 1,2,3 and peek.
    push_word(4'd1); push_word(4'd2); push_word(4'd3);
    in_valid = 1'b0;
    #1;
    check("t1_count", count, 3);
    check("t1_out_data", out_data, 1);
    peek_addr = 3'd2; #1;
    check("t1_peek2", peek_data, 3);
    peek_addr = 3'd3; #1;
    check("t1_peek3", peek_data, 0);
    peek_addr = 3'd0;
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;

    // Fill, overflow, drain.
    for (int i = 0; i < 8; i++) push_word(4'(i));
    check("t2_in_ready_full", in_ready, 0);
    check("t2_count_full", count, 8);
    in_data = 4'd9;
    step();
    in_valid = 1'b0;
    check("t2_overflow", overflow, 1);
    check("t2_count_kept", count, 8);
    out_ready = 1'b1;
    repeat (8) step();
    out_ready = 1'b0;
    #1;
    check("t2_empty_valid", out_valid, 0);
    check("t2_empty_data", out_data, 0);

    // Sustained push/pop at count=2 across pointer wrap.
    push_word(4'd10); push_word(4'd11);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_word(4'((i + 3) % 16));
      check("t3_count_steady", count, 2);
    end
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b0;
    check("t3_drained", count, 0);

    // Clear overflow, then full FIFO with simultaneous push and pop.
    reset = 1'b1; step(); reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_word(4'(15 - i));
    in_data = 4'd6; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_count", count, 7);
    check("t4_overflow", overflow, 1);
    check("t4_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (7) step();
    out_ready = 1'b0;

    // Push into empty: no bypass.
    in_valid = 1'b1; in_data = 4'd5;
    #1;
    check("t5_valid_same_cycle", out_valid, 0);
    exp_q.push_back(4'd5);
    step();
    in_valid = 1'b0;
    check("t5_valid_next", out_valid, 1);
    check("t5_data_next", out_data, 5);

    // Build count=5 with overflow set, then reset mid-stream.
    for (int i = 0; i < 7; i++) push_word(4'(i + 1));
    in_data = 4'd12;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    check("t6_pre_count", count, 5);
    check("t6_pre_overflow", overflow, 1);
    reset = 1'b1; in_valid = 1'b1; in_data = 4'd13; out_ready = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    check("t6_count", count, 0);
    check("t6_overflow", overflow, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_out_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      peek_addr = 3'(i);
      #1;
      check("t6_peek", peek_data, 0);
    end

    step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/memreg_fifo.md
# memreg_fifo

Small synchronous FIFO whose storage is a register-mapped memory array (an 8-entry x 4-bit array, forced to flip-flops by the mem2reg pass rather than inferred as a memory macro). It sits directly downstream of the memory-write test logic: it accepts a stream of data words with a valid/ready handshake, buffers them, and presents them in order to a consumer. A random-offset peek port exercises variable-index reads of the array.

## Interface
Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_data  input  WIDTH  word to enqueue.
- out_valid  output  1  out_data holds the oldest buffered word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  WIDTH  oldest word; 0 when empty.
- peek_addr  input  AW  offset from head (0 = oldest).
- peek_data  output  WIDTH  word at head+peek_addr; 0 if peek_addr >= count.
- count  output  AW+1  number of buffered words, 0..DEPTH.
- overflow  output  1  sticky: a push was attempted while full.

## Operation
- Storage: mem[0..DEPTH-1] of WIDTH bits, marked for mem2reg conversion. State: wr_ptr, rd_ptr (AW bits each), count (AW+1 bits), overflow.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- On push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0).
- On pop: rd_ptr <= rd_ptr+1 (wraps).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH). No write-through when full, even if a pop happens in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else 0. No bypass when empty: a word pushed into an empty FIFO appears the next cycle.
- peek_data = mem[(rd_ptr+peek_addr) mod DEPTH] if peek_addr < count, else 0. Purely combinational; a pop does not affect the value shown in the same cycle.
- overflow: set when in_valid && !in_ready. Cleared only by reset. The offered word is dropped, and no state other than overflow changes.
- Reset, including mid-stream: wr_ptr=0, rd_ptr=0, count=0, overflow=0, and every mem entry=0. Any push or pop in the reset cycle is ignored.
- Reset output values: in_ready=1, out_valid=0, out_data=0, peek_data=0, count=0, overflow=0.

## Timing
- All outputs are combinational from registered state; none depend combinationally on in_valid, out_ready or in_data, except that peek_data depends on peek_addr.
- Push-to-out_valid latency: 1 cycle. Throughput: 1 push and 1 pop per cycle, sustained.
- A full FIFO becomes ready 1 cycle after the pop that frees an entry.
- count, pointers and overflow update on the same edge as the handshake that causes them.

## Test plan
- Reset, then push 1,2,3 on consecutive cycles with out_ready=0 -> count=3; out_data=1; peek_addr=2 gives 3; peek_addr=3 gives 0.
- Push 8 words 0..7 -> in_ready=0 and count=8. Push 9 with in_valid=1 -> overflow=1, count stays 8. Drain -> outputs 0..7 in order, then out_valid=0 and out_data=0.
- Continuous simultaneous push/pop for 20 cycles starting from count=2 -> count stays 2; pointers wrap past 7 -> 0; output order is preserved.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> pop occurs, push is refused, count=7, overflow=1; next cycle in_ready=1.
- Empty FIFO, push 5 -> out_valid=0 in that cycle and out_valid=1 with out_data=5 the next cycle.
- Assert reset with count=5 and overflow=1 while push and pop are active -> next cycle count=0, overflow=0, in_ready=1, and all peek offsets return 0.
